bus_endpoint: RTL and testbench

BUS_ENDPOINT -- requirements
Module: bus_endpoint

---
 rtl/bus_endpoint.sv | 120 ++++++++++++
 tb/tb_bus_endpoint.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_endpoint.sv
// Bus endpoint: host-side TX FIFO feeding a shared bus and an ID-filtered
// RX FIFO draining it, with drop/misroute/underflow error reporting.
module bus_endpoint #(
   parameter int          pckg_sz   = 16,
   parameter int          deep_fifo = 8,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tx_valid,
   input  logic [pckg_sz-1:0]           tx_data,
   output logic                         tx_ready,
   output logic                         pndng,
   output logic [pckg_sz-1:0]           D_pop,
   input  logic                         pop,
   input  logic                         push,
   input  logic [pckg_sz-1:0]           D_push,
   output logic                         rx_valid,
   output logic [pckg_sz-1:0]           rx_data,
   input  logic                         rx_ready,
   output logic [$clog2(deep_fifo):0]   tx_count,
   output logic [$clog2(deep_fifo):0]   rx_count,
   output logic [7:0]                   drop_cnt,
   output logic [7:0]                   misroute_cnt,
   output logic                         underflow
);

   localparam int AW = $clog2(deep_fifo);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(deep_fifo);

   logic [pckg_sz-1:0] r_tx_mem [deep_fifo];
   logic [pckg_sz-1:0] r_rx_mem [deep_fifo];
   logic [AW-1:0]      r_tx_wp, r_tx_rp;
   logic [AW-1:0]      r_rx_wp, r_rx_rp;
   logic [CW-1:0]      r_tx_cnt, r_rx_cnt;
   logic [7:0]         r_drop, r_misroute;
   logic               r_underflow;

   logic               w_tx_wr, w_tx_rd;
   logic               w_rx_wr, w_rx_rd;
   logic               w_hit, w_drop, w_misroute;
   logic [7:0]         w_dest;

   assign tx_ready = (r_tx_cnt < DEPTH);
   assign pndng    = (r_tx_cnt != '0);
   assign D_pop    = pndng ? r_tx_mem[r_tx_rp] : '0;
   assign rx_valid = (r_rx_cnt != '0);
   assign rx_data  = rx_valid ? r_rx_mem[r_rx_rp] : '0;

   assign tx_count     = r_tx_cnt;
   assign rx_count     = r_rx_cnt;
   assign drop_cnt     = r_drop;
   assign misroute_cnt = r_misroute;
   assign underflow    = r_underflow;

   assign w_tx_wr = tx_valid & tx_ready;
   assign w_tx_rd = pop & pndng;

   // A full RX FIFO still accepts when the host drains the head this cycle
   assign w_dest     = D_push[pckg_sz-1:pckg_sz-8];
   assign w_hit      = (w_dest == id) || (w_dest == broadcast);
   assign w_rx_rd    = rx_valid & rx_ready;
   assign w_rx_wr    = push & w_hit & ((r_rx_cnt < DEPTH) | w_rx_rd);
   assign w_drop     = push & w_hit & ~w_rx_wr;
   assign w_misroute = push & ~w_hit;

   // Storage is never reset; pointers and counts define validity
   always_ff @(posedge clk) begin
      if (w_tx_wr)
         r_tx_mem[r_tx_wp] <= tx_data;
      if (w_rx_wr)
         r_rx_mem[r_rx_wp] <= D_push;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_wp     <= '0;
         r_tx_rp     <= '0;
         r_tx_cnt    <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_tx_wr)
            r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_rd)
            r_tx_rp <= r_tx_rp + 1'b1;
         if (w_tx_wr && !w_tx_rd)
            r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (!w_tx_wr && w_tx_rd)
            r_tx_cnt <= r_tx_cnt - 1'b1;
         if (pop && !pndng)
            r_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_rx_cnt   <= '0;
         r_drop     <= '0;
         r_misroute <= '0;
      end else begin
         if (w_rx_wr)
            r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_rd)
            r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_wr && !w_rx_rd)
            r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (!w_rx_wr && w_rx_rd)
            r_rx_cnt <= r_rx_cnt - 1'b1;
         if (w_drop && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
         if (w_misroute && r_misroute != 8'hFF)
            r_misroute <= r_misroute + 8'd1;
      end
   end

endmodule

// File: tb/tb_bus_endpoint.sv
// Directed bench for bus_endpoint (id=8'h02, depth 8); expected values
// are hand-computed constants.
module tb_bus_endpoint;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_valid;
   logic [15:0] tx_data;
   logic        tx_ready;
   logic        pndng;
   logic [15:0] D_pop;
   logic        pop;
   logic        push;
   logic [15:0] D_push;
   logic        rx_valid;
   logic [15:0] rx_data;
   logic        rx_ready;
   logic [3:0]  tx_count, rx_count;
   logic [7:0]  drop_cnt, misroute_cnt;
   logic        underflow;

   int n_chk  = 0;
   int n_pass = 0;

   bus_endpoint #(
      .pckg_sz(16), .deep_fifo(8), .id(8'h02), .broadcast(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_count(tx_count), .rx_count(rx_count),
      .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tx_valid = 0; pop = 0; push = 0; rx_ready = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_tx_ready"}, tx_ready, 1);
      chk({tag, "_pndng"}, pndng, 0);
      chk({tag, "_D_pop"}, D_pop, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_tx_count"}, tx_count, 0);
      chk({tag, "_rx_count"}, rx_count, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_misroute"}, misroute_cnt, 0);
      chk({tag, "_underflow"}, underflow, 0);
   endtask

   initial begin
      logic [15:0] exp_q [$];
      reset = 1; tx_data = 0; D_push = 0;
      idle();
      tick(); tick();
      chk_reset_state("rst");
      reset = 0;

      // Basic TX FWFT order
      tx_valid = 1; tx_data = 16'h0AB1; tick();
      chk("tx1_pndng", pndng, 1);
      chk("tx1_head", D_pop, 16'h0AB1);
      tx_data = 16'h0AB2; tick();
      tx_valid = 0; pop = 1; tick();
      chk("tx_pop1_head", D_pop, 16'h0AB2);
      chk("tx_pop1_cnt", tx_count, 1);
      tick();
      pop = 0;
      chk("tx_pop2_pndng", pndng, 0);
      chk("tx_pop2_head", D_pop, 0);

      // Fill TX past full
      tx_valid = 1;
      for (int i = 0; i < 9; i++) begin
         tx_data = 16'h1000 + 16'(i);
         tick();
         if (i == 7) begin
            chk("tx_full_ready", tx_ready, 0);
            chk("tx_full_cnt", tx_count, 8);
         end
      end
      tx_valid = 0;
      chk("tx_ovf_cnt", tx_count, 8);
      chk("tx_ovf_head", D_pop, 16'h1000);
      pop = 1; tick(); pop = 0;
      chk("tx_cnt7", tx_count, 7);
      tx_valid = 1; tx_data = 16'h2000; pop = 1; tick();
      idle();
      chk("tx_wr_pop_cnt", tx_count, 7);
      chk("tx_wr_pop_head", D_pop, 16'h1002);
      for (int i = 2; i < 8; i++) exp_q.push_back(16'h1000 + 16'(i));
      exp_q.push_back(16'h2000);
      pop = 1;
      while (exp_q.size() > 0) begin
         chk("tx_drain", D_pop, exp_q.pop_front());
         tick();
      end
      pop = 0;
      chk("tx_drained", pndng, 0);

      // Underflow is sticky and changes nothing else
      pop = 1; tick(); pop = 0;
      chk("uf_set", underflow, 1);
      tick();
      chk("uf_held", underflow, 1);
      chk("uf_cnt", tx_count, 0);

      // RX address filter
      push = 1; D_push = 16'h0255; tick();
      chk("rx_own_valid", rx_valid, 1);
      chk("rx_own_data", rx_data, 16'h0255);
      D_push = 16'hFF11; tick();
      chk("rx_bcast_cnt", rx_count, 2);
      D_push = 16'h0377; tick();
      push = 0;
      chk("rx_mis_cnt", misroute_cnt, 1);
      chk("rx_mis_rxcnt", rx_count, 2);
      rx_ready = 1; tick();
      chk("rx_pop_data", rx_data, 16'hFF11);
      chk("rx_pop_cnt", rx_count, 1);
      tick();
      chk("rx_empty_valid", rx_valid, 0);
      chk("rx_empty_data", rx_data, 0);
      tick();
      rx_ready = 0;
      chk("rx_empty_rdy", rx_count, 0);

      // RX full: drop, bypass accept, saturation
      push = 1;
      for (int i = 0; i < 8; i++) begin
         D_push = 16'h0200 + 16'(i);
         tick();
      end
      chk("rx_full_cnt", rx_count, 8);
      D_push = 16'h02AA; tick();
      chk("rx_drop1", drop_cnt, 1);
      chk("rx_drop1_cnt", rx_count, 8);
      D_push = 16'h02BB; rx_ready = 1; tick();
      rx_ready = 0;
      chk("rx_bypass_cnt", rx_count, 8);
      chk("rx_bypass_drop", drop_cnt, 1);
      chk("rx_bypass_head", rx_data, 16'h0201);
      D_push = 16'h02CC;
      for (int i = 0; i < 300; i++) tick();
      push = 0;
      chk("rx_drop_sat", drop_cnt, 8'hFF);

      // Reset mid-traffic with concurrent TX and RX activity
      reset = 1; tick(); reset = 0;
      chk("rst2_rx_cnt", rx_count, 0);
      pop = 1; tick(); pop = 0;
      tx_valid = 1; push = 1;
      for (int i = 0; i < 5; i++) begin
         tx_data = 16'h3000 + 16'(i);
         D_push = 16'h0240 + 16'(i);
         if (i == 3) push = 0;
         tick();
      end
      idle();
      chk("mid_tx_cnt", tx_count, 5);
      chk("mid_rx_cnt", rx_count, 3);
      chk("mid_uf", underflow, 1);
      reset = 1; tx_valid = 1; pop = 1; push = 1; rx_ready = 1;
      tx_data = 16'h3F3F; D_push = 16'h0266;
      tick();
      idle(); reset = 0;
      chk_reset_state("rst3");
      tx_valid = 1; tx_data = 16'h0ABC; tick();
      tx_valid = 0;
      chk("post_rst_head", D_pop, 16'h0ABC);
      chk("post_rst_cnt", tx_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
